// File: rtl/posit_io_pkg.sv
// Shared FSM encoding and sizing for the posit byte-serial I/O block.
// Default geometry is N=16 bits over an 8-bit lane.
package posit_io_pkg;

  typedef enum logic [1:0] {
    ST_RX  = 2'd0,
    ST_CAP = 2'd1,
    ST_TX  = 2'd2
  } state_e;

  localparam int DEF_N = 16;
  localparam int DEF_W = 8;

  localparam int BYTES_PER_OP = DEF_N / DEF_W;
  localparam int RX_BYTES     = 2 * DEF_N / DEF_W;

  localparam int CNT_W = 8;
  localparam int IDX_W = 8;

endpackage

// File: rtl/posit_byte_io.sv
// Byte-serial wrapper around a combinational posit adder: gathers two
// operands LSB-first, captures the sum, and streams it back out LSB-first.
module posit_byte_io
  import posit_io_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [W-1:0]     i_data,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_abort,
  output logic [N-1:0]     o_in_1,
  output logic [N-1:0]     o_in_2,
  input  logic [N-1:0]     i_res,
  output logic [W-1:0]     o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_done,
  output logic [CNT_W-1:0] o_count
);

  localparam int BPO = N / W;
  localparam int RXB = 2 * N / W;
  localparam int OW  = $clog2(N);

  state_e           r_state;
  state_e           w_state_nx;
  logic [IDX_W-1:0] r_k;
  logic [IDX_W-1:0] w_k_nx;
  logic [IDX_W-1:0] r_j;
  logic [IDX_W-1:0] w_j_nx;

  logic [N-1:0]     r_in_1;
  logic [N-1:0]     r_in_2;
  logic [N-1:0]     r_res;
  logic [CNT_W-1:0] r_count;
  logic             r_done;

  logic             w_acc_in;
  logic             w_acc_out;
  logic             w_last_in;
  logic             w_last_out;
  logic             w_op2;
  logic [IDX_W-1:0] w_lane;
  logic [OW-1:0]    w_base;
  logic [OW-1:0]    w_obase;

  assign o_ready = (r_state == ST_RX);
  assign o_valid = (r_state == ST_TX);

  assign w_acc_in   = o_ready && i_valid;
  assign w_acc_out  = o_valid && i_ready;
  assign w_last_in  = (r_k == IDX_W'(RXB - 1));
  assign w_last_out = (r_j == IDX_W'(BPO - 1));

  assign w_op2   = (r_k >= IDX_W'(BPO));
  assign w_lane  = w_op2 ? (r_k - IDX_W'(BPO)) : r_k;
  assign w_base  = OW'(int'(w_lane) * W);
  assign w_obase = OW'(int'(r_j) * W);

  always_comb begin
    w_state_nx = r_state;
    w_k_nx     = r_k;
    w_j_nx     = r_j;
    if (i_abort) begin
      w_state_nx = ST_RX;
      w_k_nx     = '0;
      w_j_nx     = '0;
    end else begin
      unique case (r_state)
        ST_RX: begin
          if (w_acc_in) begin
            if (w_last_in) begin
              w_state_nx = ST_CAP;
              w_k_nx     = '0;
            end else begin
              w_k_nx = r_k + IDX_W'(1);
            end
          end
        end
        ST_CAP: begin
          w_state_nx = ST_TX;
          w_j_nx     = '0;
        end
        ST_TX: begin
          if (w_acc_out) begin
            if (w_last_out) begin
              w_state_nx = ST_RX;
              w_j_nx     = '0;
            end else begin
              w_j_nx = r_j + IDX_W'(1);
            end
          end
        end
        default: begin
          w_state_nx = ST_RX;
          w_k_nx     = '0;
          w_j_nx     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_RX;
      r_k     <= '0;
      r_j     <= '0;
    end else begin
      r_state <= w_state_nx;
      r_k     <= w_k_nx;
      r_j     <= w_j_nx;
    end
  end

  // Abort blocks every datapath write so operands and count survive it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_in_1  <= '0;
      r_in_2  <= '0;
      r_res   <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!i_abort) begin
        if (w_acc_in) begin
          if (w_op2) r_in_2[w_base +: W] <= i_data;
          else       r_in_1[w_base +: W] <= i_data;
        end
        if (r_state == ST_CAP) r_res <= i_res;
        if (w_acc_out && w_last_out) begin
          r_done  <= 1'b1;
          r_count <= r_count + CNT_W'(1);
        end
      end
    end
  end

  assign o_in_1  = r_in_1;
  assign o_in_2  = r_in_2;
  assign o_data  = r_res[w_obase +: W];
  assign o_done  = r_done;
  assign o_count = r_count;

endmodule
